// File: rtl/router_src_arbiter.sv
// Packet-granular round-robin arbiter feeding router_top's data_in/pkt_valid port.
// Paces bytes against router_busy, drops addr==3 packets and keeps saturating status counters.
module router_src_arbiter #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]   src_ready,
    input  logic               router_busy,
    input  logic               router_err,
    output logic [7:0]         data_in,
    output logic               pkt_valid,
    output logic [N_SRC-1:0]   grant,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   perr_cnt,
    output logic               proto_err
);
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, DROP} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      g_idx, g_nxt, rr_ptr, rr_nxt, pick, g_inc;
    logic [N_SRC-1:0]   grant_nxt;
    logic [6:0]         rem, rem_nxt;
    logic [7:0]         data_nxt, cur_byte;
    logic               pv_nxt, proto_nxt, cur_valid, done, err_q;
    logic [CNT_W-1:0]   pkt_nxt, drop_nxt;
    logic [IW-1:0]      rr_idx [N_SRC];
    logic [7:0]         src_byte [N_SRC];

    for (genvar k = 0; k < N_SRC; k++) begin : g_lane
        assign rr_idx[k]   = IW'((int'(rr_ptr) + k) % N_SRC);
        assign src_byte[k] = src_data[8*k +: 8];
    end

    // Scan from the far end so the candidate closest to rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = N_SRC - 1; k >= 0; k--)
            if (src_valid[rr_idx[k]]) pick = rr_idx[k];
    end

    assign cur_byte  = src_byte[g_idx];
    assign cur_valid = src_valid[g_idx];
    assign g_inc     = (g_idx == IW'(N_SRC - 1)) ? '0 : g_idx + IW'(1);
    assign src_ready = (state != IDLE && !router_busy) ? grant : '0;

    always_comb begin
        state_nxt = state;
        g_nxt     = g_idx;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        rem_nxt   = rem;
        data_nxt  = data_in;
        pv_nxt    = pkt_valid;
        pkt_nxt   = pkt_cnt;
        drop_nxt  = drop_cnt;
        proto_nxt = proto_err;
        done      = 1'b0;
        case (state)
            IDLE: if (|src_valid) begin
                state_nxt        = HDR;
                g_nxt            = pick;
                grant_nxt        = '0;
                grant_nxt[pick]  = 1'b1;
            end
            HDR: if (!router_busy) begin
                if (cur_valid) begin
                    if (cur_byte[1:0] == 2'b11) begin
                        rem_nxt   = {1'b0, cur_byte[7:2]} + 7'd1;
                        state_nxt = DROP;
                    end else begin
                        data_nxt  = cur_byte;
                        pv_nxt    = 1'b1;
                        rem_nxt   = {1'b0, cur_byte[7:2]};
                        state_nxt = (cur_byte[7:2] != 6'd0) ? PAY : PAR;
                    end
                end else begin
                    pv_nxt = 1'b0;
                end
            end
            PAY: if (!router_busy && cur_valid) begin
                data_nxt = cur_byte;
                pv_nxt   = 1'b1;
                rem_nxt  = rem - 7'd1;
                if (rem == 7'd1) state_nxt = PAR;
            end
            PAR: if (!router_busy && cur_valid) begin
                data_nxt = cur_byte;
                pv_nxt   = 1'b0;
                if (~&pkt_cnt) pkt_nxt = pkt_cnt + CNT_W'(1);
                done     = 1'b1;
            end
            DROP: if (!router_busy && cur_valid) begin
                rem_nxt = rem - 7'd1;
                if (rem == 7'd1) begin
                    if (~&drop_cnt) drop_nxt = drop_cnt + CNT_W'(1);
                    done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Source went quiet mid-packet: abandon it and flag the protocol breach.
        if ((state == PAY || state == PAR || state == DROP) && !router_busy && !cur_valid) begin
            proto_nxt = 1'b1;
            pv_nxt    = 1'b0;
            done      = 1'b1;
        end
        if (done) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            rr_nxt    = g_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            g_idx     <= '0;
            grant     <= '0;
            rr_ptr    <= '0;
            rem       <= '0;
            data_in   <= '0;
            pkt_valid <= 1'b0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            g_idx     <= g_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            rem       <= rem_nxt;
            data_in   <= data_nxt;
            pkt_valid <= pv_nxt;
            pkt_cnt   <= pkt_nxt;
            drop_cnt  <= drop_nxt;
            proto_err <= proto_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            perr_cnt <= '0;
        end else begin
            err_q <= router_err;
            if (router_err && !err_q && ~&perr_cnt) perr_cnt <= perr_cnt + CNT_W'(1);
        end
    end
endmodule
